// File: rtl/uart_tx_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue_pkg
// Description : Shared constants and FSM state encoding for the UART
//               transmit queue and its byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_queue_pkg;

  // Width of one UART character as held in the queue
  localparam int UART_BYTE_WIDTH = 8;

  // Transmit handshake sequencer states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } tx_state_e;

endpackage : uart_tx_queue_pkg
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Generic synchronous circular FIFO with registered count,
//               full/empty flags and a sticky overflow flag. A push at full
//               is still accepted when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic                  i_clear_overflow,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH:0] C_FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_reject;

  assign w_full   = (r_count == C_FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_pop    = i_rd_en && !w_empty;
  // A pop on the same edge frees a slot, so a push at full is still legal
  assign w_push   = i_wr_en && (!w_full || w_pop);
  assign w_reject = i_wr_en && w_full && !w_pop;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a rejected push beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_reject) begin
      r_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Storage array, intentionally left without reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule : uart_byte_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte queue feeding a UART transmitter. Pops one byte at a
//               time into a held data register, issues a one-cycle request
//               and tracks the UART busy flag (synchronized) to completion.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       masterClock,
  input  logic                       reset,
  input  logic [UART_BYTE_WIDTH-1:0] wrData,
  input  logic                       wrEnable,
  output logic                       full,
  output logic                       empty,
  output logic [ADDR_WIDTH:0]        count,
  output logic                       overflow,
  input  logic                       clearOverflow,
  output logic [UART_BYTE_WIDTH-1:0] txData,
  output logic                       txRequest,
  input  logic                       txActive
);

  tx_state_e                  r_state;
  tx_state_e                  w_state_next;
  logic                       r_sync_meta;
  logic                       r_tx_active_sync;
  logic [UART_BYTE_WIDTH-1:0] r_tx_data;
  logic                       r_tx_request;
  logic                       w_pop;
  logic                       w_empty;
  logic [UART_BYTE_WIDTH-1:0] w_head;

  uart_byte_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (UART_BYTE_WIDTH)
  ) u_fifo (
    .clk              (masterClock),
    .rst_n            (reset),
    .i_wr_en          (wrEnable),
    .i_wr_data        (wrData),
    .i_rd_en          (w_pop),
    .i_clear_overflow (clearOverflow),
    .o_rd_data        (w_head),
    .o_full           (full),
    .o_empty          (w_empty),
    .o_count          (count),
    .o_overflow       (overflow)
  );

  // Two-flop synchronizer for the UART busy flag from the divided clock domain
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      r_sync_meta      <= 1'b0;
      r_tx_active_sync <= 1'b0;
    end else begin
      r_sync_meta      <= txActive;
      r_tx_active_sync <= r_sync_meta;
    end
  end

  // Next-state and pop decode; never start a byte while the UART is busy
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !r_tx_active_sync) begin
          w_pop        = 1'b1;
          w_state_next = REQUEST;
        end
      end
      REQUEST:    w_state_next = WAIT_START;
      WAIT_START: if (r_tx_active_sync)  w_state_next = WAIT_DONE;
      WAIT_DONE:  if (!r_tx_active_sync) w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  // State, registered request pulse and held transmit byte
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_tx_request <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_tx_request <= (w_state_next == REQUEST);
      if (w_pop) r_tx_data <= w_head;
    end
  end

  assign empty     = w_empty;
  assign txData    = r_tx_data;
  assign txRequest = r_tx_request;

endmodule : uart_tx_queue
`default_nettype wire
